// File: rtl/max_cal_seq_ctrl_if.sv
// Bundles the payload-beat stream and the result stream seen by max_cal_seq_ctrl.
// slave  : controller view (consumes beats, produces results)
// master : producer/consumer view (drives beats, accepts results)
interface max_cal_seq_ctrl_if #(
  parameter int BEAT_CNT_W = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [255:0]          s_data;
  logic                  s_last;
  logic [7:0]            s_keep;
  logic                  r_valid;
  logic                  r_ready;
  logic [31:0]           r_max;
  logic [BEAT_CNT_W-1:0] r_beats;

  modport slave (
    input  s_valid, s_data, s_last, s_keep, r_ready,
    output s_ready, r_valid, r_max, r_beats
  );

  modport master (
    output s_valid, s_data, s_last, s_keep, r_ready,
    input  s_ready, r_valid, r_max, r_beats
  );
endinterface

// File: rtl/max_cal_seq_ctrl.sv
// max_cal_seq_ctrl: sequences an external max_cal_block_nonblocking that computes
// the unsigned maximum of all 32-bit words of a packet. Beats go to the block,
// packet boundaries ride a marker pipeline matched to the block latency, and each
// packet's max plus its beat count are captured into a small result FIFO.
// Optional build macro: MAXCTL_LANE_MASK_EN (zero lanes whose s_keep bit is 0).
module max_cal_seq_ctrl #(
  parameter int PIPE_LAT   = 3,
  parameter int RES_DEPTH  = 4,
  parameter int BEAT_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  max_cal_seq_ctrl_if.slave   bus,
  output logic [255:0]        mc_payload,
  output logic                mc_ce,
  output logic                mc_clear,
  input  logic [31:0]         mc_max
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(RES_DEPTH);
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(RES_DEPTH - 1);
  localparam logic [BEAT_CNT_W-1:0] ONE_BEAT = BEAT_CNT_W'(1);

  typedef enum logic {
    ST_SOP  = 1'b0,   // next accepted beat starts a packet
    ST_BODY = 1'b1    // inside a packet
  } pkt_state_e;

  pkt_state_e            state_q, state_d;
  logic                  sop_now;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic                  ce_q;
  logic                  accept;
  logic                  s_ready_int;
  logic [7:0]            lane_en;

  logic [PIPE_LAT-1:0]   sop_sr_q;
  logic [PIPE_LAT-1:0]   eop_sr_q;
  logic [BEAT_CNT_W-1:0] cnt_sr_q [PIPE_LAT];

  logic [31:0]           fifo_max_q [RES_DEPTH];
  logic [BEAT_CNT_W-1:0] fifo_cnt_q [RES_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_lvl_q;
  logic [CNT_W-1:0]      pending_q;
  logic                  push, pop, r_valid_int, last_acc;

  // The oldest marker bit is never consumed; only bit PIPE_LAT-2 drives clear.
  logic unused_sop_msb;
  assign unused_sop_msb = sop_sr_q[PIPE_LAT-1];

  // Handshake: ready only once the block is enabled and a result slot is reserved.
  assign s_ready_int = ce_q && (pending_q < DEPTH_C);
  assign accept      = bus.s_valid && s_ready_int;
  assign bus.s_ready = s_ready_int;
  assign mc_ce       = ce_q;
  assign last_acc    = accept && bus.s_last;

  // Payload lanes: zero on bubbles (neutral for unsigned max) and on masked lanes.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
`ifdef MAXCTL_LANE_MASK_EN
    assign lane_en[gi] = bus.s_keep[gi];
`else
    assign lane_en[gi] = 1'b1;
`endif
    assign mc_payload[32*gi +: 32] = (accept && lane_en[gi]) ? bus.s_data[32*gi +: 32] : 32'd0;
  end

`ifndef MAXCTL_LANE_MASK_EN
  logic unused_keep;
  assign unused_keep = ^bus.s_keep;
`endif

  // CE rises on the first edge after reset release and stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ce_q <= 1'b0;
    else        ce_q <= 1'b1;
  end

  // Packet framing state and saturating beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SOP;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next framing state; beat count restarts at 1 on the first beat of a packet.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    sop_now    = (state_q == ST_SOP);
    if (accept) begin
      state_d = bus.s_last ? ST_SOP : ST_BODY;
      if (sop_now)                 beat_cnt_d = ONE_BEAT;
      else if (beat_cnt_q != '1)   beat_cnt_d = beat_cnt_q + ONE_BEAT;
    end
  end

  // Marker pipeline tracking sop/eop/count alongside the block's data pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_sr_q <= '0;
      eop_sr_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) cnt_sr_q[i] <= '0;
    end else begin
      sop_sr_q    <= {sop_sr_q[PIPE_LAT-2:0], accept & sop_now};
      eop_sr_q    <= {eop_sr_q[PIPE_LAT-2:0], last_acc};
      cnt_sr_q[0] <= beat_cnt_d;
      for (int i = 1; i < PIPE_LAT; i++) cnt_sr_q[i] <= cnt_sr_q[i-1];
    end
  end

  // Clear lands on the edge where a packet's first beat reaches second_layer.
  assign mc_clear = sop_sr_q[PIPE_LAT-2];

  assign push        = eop_sr_q[PIPE_LAT-1];
  assign r_valid_int = (fifo_cnt_lvl_q != '0);
  assign pop         = r_valid_int && bus.r_ready;

  // Result storage; contents need no reset because the level counter gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_max_q[wr_ptr_q] <= mc_max;
      fifo_cnt_q[wr_ptr_q] <= cnt_sr_q[PIPE_LAT-1];
    end
  end

  // FIFO pointers, fill level and in-flight packet credits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_lvl_q <= '0;
      pending_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_lvl_q <= fifo_cnt_lvl_q + 1'b1;
      else if (!push && pop) fifo_cnt_lvl_q <= fifo_cnt_lvl_q - 1'b1;
      if (last_acc && !pop)      pending_q <= pending_q + 1'b1;
      else if (!last_acc && pop) pending_q <= pending_q - 1'b1;
    end
  end

  // Result outputs come straight from the FIFO head; zero when empty.
  assign bus.r_valid = r_valid_int;
  assign bus.r_max   = r_valid_int ? fifo_max_q[rd_ptr_q] : 32'd0;
  assign bus.r_beats = r_valid_int ? fifo_cnt_q[rd_ptr_q] : '0;

endmodule
